// File: rtl/enc_mac_sched.sv
// Time-multiplexed fully-connected layer: y[j] = sum_i W[j][i]*x[i] + b[j] on one shared multiplier.
// Define ENC_MAC_SCHED_SAT_EN to saturate each result instead of wrapping it.
module enc_mac_sched #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 12,
    parameter int N_IN    = 6,
    parameter int N_OUT   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [BITSIZE*N_IN*N_OUT-1:0]   w,
    input  logic [BITSIZE*N_IN-1:0]         x,
    input  logic [BITSIZE*N_OUT-1:0]        b,
    output logic [BITSIZE*N_OUT-1:0]        y,
    output logic                            busy,
    output logic                            done
);

    localparam int ACC_W = 2*BITSIZE + $clog2(N_IN) + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam int I_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int J_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int K_W   = (N_IN*N_OUT > 1) ? $clog2(N_IN*N_OUT) : 1;
    localparam logic [I_W-1:0] I_LAST = I_W'(N_IN-1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT-1);

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, BIAS = 2'd2, DONE = 2'd3} state_t;

    state_t                     state_r, state_s;
    logic signed [BITSIZE-1:0]  w_mem_r [N_IN*N_OUT];
    logic signed [BITSIZE-1:0]  x_mem_r [N_IN];
    logic signed [BITSIZE-1:0]  b_mem_r [N_OUT];
    logic signed [BITSIZE-1:0]  y_mem_r [N_OUT];
    logic [I_W-1:0]             i_r;
    logic [J_W-1:0]             j_r;
    logic [K_W-1:0]             k_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic                       busy_r, done_r;
    logic signed [2*BITSIZE-1:0] prod_s;
    logic signed [ACC_W-1:0]    acc_add_s;
    logic signed [SUM_W-1:0]    sum_s, shifted_s;
    logic signed [BITSIZE-1:0]  res_s;

    // Narrow the rescaled sum to the output word (clamp or two's-complement wrap).
    function automatic logic signed [BITSIZE-1:0] reduce(input logic signed [SUM_W-1:0] v);
`ifdef ENC_MAC_SCHED_SAT_EN
        logic [SUM_W-BITSIZE:0] top;
        top = v[SUM_W-1:BITSIZE-1];
        if ((&top) || !(|top)) begin
            reduce = v[BITSIZE-1:0];
        end else if (v[SUM_W-1]) begin
            reduce = {1'b1, {(BITSIZE-1){1'b0}}};
        end else begin
            reduce = {1'b0, {(BITSIZE-1){1'b1}}};
        end
`else
        reduce = v[BITSIZE-1:0];
`endif
    endfunction

    // Shared multiplier, accumulate path and bias/rescale path.
    always_comb begin
        prod_s    = w_mem_r[k_r] * x_mem_r[i_r];
        acc_add_s = acc_r + {{(ACC_W-2*BITSIZE){prod_s[2*BITSIZE-1]}}, prod_s};
        sum_s     = {acc_r[ACC_W-1], acc_r}
                  + {{(SUM_W-BITSIZE-FRAC){b_mem_r[j_r][BITSIZE-1]}}, b_mem_r[j_r], {FRAC{1'b0}}};
        shifted_s = sum_s >>> FRAC;
        res_s     = reduce(shifted_s);
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = MAC;
                else       state_s = IDLE;
            end
            MAC: begin
                if (i_r == I_LAST) state_s = BIAS;
                else               state_s = MAC;
            end
            BIAS: begin
                if (j_r == J_LAST) state_s = DONE;
                else               state_s = MAC;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Operand capture, indices, accumulator and result words.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < N_IN*N_OUT; n++) w_mem_r[n] <= '0;
            for (int n = 0; n < N_IN; n++)       x_mem_r[n] <= '0;
            for (int n = 0; n < N_OUT; n++)      b_mem_r[n] <= '0;
            for (int n = 0; n < N_OUT; n++)      y_mem_r[n] <= '0;
            acc_r <= '0;
            i_r   <= '0;
            j_r   <= '0;
            k_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        for (int n = 0; n < N_IN*N_OUT; n++) w_mem_r[n] <= w[n*BITSIZE +: BITSIZE];
                        for (int n = 0; n < N_IN; n++)       x_mem_r[n] <= x[n*BITSIZE +: BITSIZE];
                        for (int n = 0; n < N_OUT; n++)      b_mem_r[n] <= b[n*BITSIZE +: BITSIZE];
                        acc_r <= '0;
                        i_r   <= '0;
                        j_r   <= '0;
                        k_r   <= '0;
                    end
                end
                MAC: begin
                    acc_r <= acc_add_s;
                    i_r   <= i_r + I_W'(1);
                    k_r   <= k_r + K_W'(1);
                end
                BIAS: begin
                    y_mem_r[j_r] <= res_s;
                    acc_r        <= '0;
                    i_r          <= '0;
                    if (j_r != J_LAST) j_r <= j_r + J_W'(1);
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags registered from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_y
        assign y[g*BITSIZE +: BITSIZE] = y_mem_r[g];
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_enc_mac_sched.sv
// Directed scoreboard bench for enc_mac_sched; expected results come from a longint reference model.
module tb_enc_mac_sched;

    localparam int BITSIZE = 16;
    localparam int FRAC    = 12;
    localparam int N_IN    = 6;
    localparam int N_OUT   = 2;
    localparam int W_W     = BITSIZE*N_IN*N_OUT;
    localparam int X_W     = BITSIZE*N_IN;
    localparam int Y_W     = BITSIZE*N_OUT;

    logic           clk = 1'b0;
    logic           reset_s;
    logic           start_s;
    logic [W_W-1:0] w_s;
    logic [X_W-1:0] x_s;
    logic [Y_W-1:0] b_s;
    logic [Y_W-1:0] y_s;
    logic           busy_s, done_s;

    int checks = 0;
    int failures = 0;
    logic [Y_W-1:0] exp_q[$];

    enc_mac_sched #(.BITSIZE(BITSIZE), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .reset(reset_s), .start(start_s),
        .w(w_s), .x(x_s), .b(b_s),
        .y(y_s), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [Y_W-1:0] model(input logic [W_W-1:0] wv, input logic [X_W-1:0] xv,
                                             input logic [Y_W-1:0] bv);
        logic [Y_W-1:0] res;
        longint acc, r;
        res = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                acc += longint'($signed(wv[(j*N_IN+i)*BITSIZE +: BITSIZE]))
                     * longint'($signed(xv[i*BITSIZE +: BITSIZE]));
            acc += longint'($signed(bv[j*BITSIZE +: BITSIZE])) <<< FRAC;
            r = acc >>> FRAC;
`ifdef ENC_MAC_SCHED_SAT_EN
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
`endif
            res[j*BITSIZE +: BITSIZE] = r[BITSIZE-1:0];
        end
        return res;
    endfunction

    // One evaluation over a fixed 20-cycle window; optional extra start pulses land at edges k+ra / k+rb.
    task automatic run_eval(input string tag, input logic [W_W-1:0] wv, input logic [X_W-1:0] xv,
                            input logic [Y_W-1:0] bv, input int ra, input int rb);
        int done_at, done_cnt, busy_cnt;
        logic [Y_W-1:0] y_done, exp_now;
        exp_q.push_back(model(wv, xv, bv));
        @(negedge clk);
        w_s = wv; x_s = xv; b_s = bv; start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s  = 1'b0;
        busy_cnt = busy_s ? 1 : 0;
        done_at  = -1;
        done_cnt = 0;
        y_done   = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy_s) busy_cnt++;
            if (done_s) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    y_done  = y_s;
                end
            end
            start_s = 1'b0;
            if (c == ra - 1 || c == rb - 1) begin
                start_s = 1'b1;
                x_s = ~xv;
            end
        end
        start_s = 1'b0;
        exp_now = exp_q.pop_front();
        check({tag, "_latency"}, 64'(done_at), 64'd14);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd15);
        check({tag, "_y_at_done"}, 64'(y_done), 64'(exp_now));
        check({tag, "_y_hold"}, 64'(y_s), 64'(exp_now));
    endtask

    initial begin
        logic [W_W-1:0] wr;
        logic [X_W-1:0] xr;
        logic [Y_W-1:0] br;
        reset_s = 1'b1; start_s = 1'b0; w_s = '0; x_s = '0; b_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy_s), 64'd0);
        check("reset_done", 64'(done_s), 64'd0);
        check("reset_y", 64'(y_s), 64'd0);
        reset_s = 1'b0;

        run_eval("half", {12{16'h1000}}, {6{16'h0800}}, {2{16'h0400}}, -10, -10);
        check("half_value", 64'(y_s), 64'h3400_3400);
        run_eval("neg", {12{16'h1000}}, {6{16'hF000}}, {2{16'h0000}}, -10, -10);
        check("neg_value", 64'(y_s), 64'hA000_A000);
        run_eval("big", {12{16'h7FFF}}, {6{16'h7FFF}}, {2{16'h0000}}, -10, -10);
        run_eval("restart", {{6{16'h2000}}, {6{16'hF800}}}, {6{16'h0C00}}, {16'h0100, 16'hFF00}, 5, 15);

        for (int n = 0; n < N_IN*N_OUT; n++) wr[n*BITSIZE +: BITSIZE] = 16'($urandom_range(0, 65535));
        for (int n = 0; n < N_IN; n++)       xr[n*BITSIZE +: BITSIZE] = 16'($urandom_range(0, 65535));
        for (int n = 0; n < N_OUT; n++)      br[n*BITSIZE +: BITSIZE] = 16'($urandom_range(0, 65535));
        run_eval("random", wr, xr, br, -10, -10);

        // Abort an evaluation mid-flight after y[0] has already been written.
        @(negedge clk);
        w_s = {12{16'h1000}}; x_s = {6{16'h0800}}; b_s = {2{16'h0400}}; start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        repeat (7) @(negedge clk);
        reset_s = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy_s), 64'd0);
        check("abort_done", 64'(done_s), 64'd0);
        check("abort_y", 64'(y_s), 64'd0);
        reset_s = 1'b0;
        run_eval("post_reset", {12{16'h1000}}, {6{16'h0800}}, {2{16'h0400}}, -10, -10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
